// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared constants for the sequential Booth multiplier:
//                default operand width, FSM state encoding and the Booth
//                {Q0, Q(-1)} pair decode.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Booth recoding of {Q0, Q(-1)}; 00 and 11 are no-ops
    localparam logic [1:0] c_BOOTH_ADD = 2'b01;
    localparam logic [1:0] c_BOOTH_SUB = 2'b10;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
//  Module      : booth_step
//  Description : One combinational radix-2 Booth iteration on N-bit
//                registers: conditional add/subtract of M into A selected by
//                {Q0, Q(-1)}, then arithmetic right shift of {A, Q, Q(-1)}.
//  Ports       : i_a   - accumulator A
//                i_m   - multiplicand M
//                i_q   - multiplier register Q (Q0 = i_q[0])
//                i_qm1 - Q(-1) bit
//                o_a / o_q / o_qm1 - shifted {A, Q, Q(-1)} after the step
//  Revision    : 1.0  initial release
// ============================================================================
module booth_step
    import mult_pkg::*;
#(
    parameter int N = c_DEFAULT_WIDTH + 1
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_m,
    input  logic [N-1:0] i_q,
    input  logic         i_qm1,
    output logic [N-1:0] o_a,
    output logic [N-1:0] o_q,
    output logic         o_qm1
);

    logic [N-1:0] w_sum;

    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_qm1})
            c_BOOTH_SUB: w_sum = i_a - i_m;
            c_BOOTH_ADD: w_sum = i_a + i_m;
            default:     w_sum = i_a;
        endcase
    end

    // Operands are at most N-1 significant bits sign-extended to N, so the
    // add/subtract cannot overflow and w_sum[N-1] is the true sign.
    assign o_a   = {w_sum[N-1], w_sum[N-1:1]};
    assign o_q   = {w_sum[0], i_q[N-1:1]};
    assign o_qm1 = i_q[0];

endmodule : booth_step
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq
//  Description : Sequential radix-2 Booth multiplier, signed or unsigned,
//                one Booth step per clock over WIDTH+1-bit registers.
//                IDLE -> RUN (WIDTH+1 steps) -> DONE (done pulse) -> IDLE.
//  Ports       : clk       - rising-edge clock
//                reset     - asynchronous active-low reset
//                start     - request a multiply (sampled in IDLE only)
//                is_signed - 1: two's-complement operands, 0: unsigned
//                abort     - cancel an operation in RUN
//                A_in/B_in - multiplier / multiplicand operands
//                busy      - high while in RUN
//                done      - one-cycle pulse when Hi/Lo are updated
//                Hi/Lo     - upper / lower halves of the 2*WIDTH product
//  Revision    : 1.0  initial release
// ============================================================================
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             abort,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int               c_N         = WIDTH + 1;
    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_N-1:0]   r_m;
    logic [c_N-1:0]   r_a;
    logic [c_N-1:0]   r_q;
    logic             r_qm1;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [c_N-1:0]   w_a_nxt;
    logic [c_N-1:0]   w_q_nxt;
    logic             w_qm1_nxt;
    logic             w_last;
    logic             w_accept;
    logic             w_step;
    logic             w_unused_a_top;

    booth_step #(
        .N (c_N)
    ) u_booth_step (
        .i_a   (r_a),
        .i_m   (r_m),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .o_a   (w_a_nxt),
        .o_q   (w_q_nxt),
        .o_qm1 (w_qm1_nxt)
    );

    assign w_last   = (r_cnt == c_LAST_STEP);
    assign w_accept = (r_state == c_ST_IDLE) && start;
    // abort wins over the step: a cancelled cycle leaves every register alone
    assign w_step   = (r_state == c_ST_RUN) && !abort;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (abort) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_last) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m   <= '0;
            r_a   <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_accept) begin
            r_m   <= {is_signed & B_in[WIDTH-1], B_in};
            r_q   <= {is_signed & A_in[WIDTH-1], A_in};
            r_a   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_qm1 <= w_qm1_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                // {A,Q} holds a 2*WIDTH+2 bit product; keep its low 2*WIDTH bits
                r_hi <= {w_a_nxt[WIDTH-2:0], w_q_nxt[WIDTH]};
                r_lo <= w_q_nxt[WIDTH-1:0];
            end
        end
    end

    // The two top accumulator bits are only sign/guard bits of the product
    assign w_unused_a_top = ^w_a_nxt[WIDTH:WIDTH-1];

    assign busy = (r_state == c_ST_RUN);
    assign done = (r_state == c_ST_DONE);
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule : mult_seq
`default_nettype wire

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+2), iteration-counter width; derived, not overridden.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  request a multiply; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 abort  input  1  synchronous cancel of an operation in progress.
REQ-008 A_in  input  WIDTH  multiplier operand; sampled with start.
REQ-009 B_in  input  WIDTH  multiplicand operand; sampled with start.
REQ-010 busy  output  1  high while the state is RUN.
REQ-011 done  output  1  one-cycle pulse when a result is written to Hi/Lo.
REQ-012 Hi  output  WIDTH  upper half of the 2*WIDTH-bit product.
REQ-013 Lo  output  WIDTH  lower half of the 2*WIDTH-bit product.

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE with start=1 at edge k: latch operands, extended to WIDTH+1 bits (sign extension if is_signed, zero extension otherwise), clear the accumulator and Q(-1) bit, set counter=0, and go to RUN.
REQ-016 RUN: each edge performs one radix-2 Booth step on the WIDTH+1-bit registers: Q0,Q(-1)=10 subtract M; 01 add M; 00/11 no operation; then arithmetic right shift of {A,Q,Q(-1)}, preserving the sign of A.
REQ-017 RUN SHALL perform exactly WIDTH+1 steps (edges k+1..k+WIDTH+1); the last step writes Hi/Lo from the low 2*WIDTH bits of the product and moves to DONE.
REQ-018 done SHALL be high only in DONE (the cycle after edge k+WIDTH+1); DONE goes to IDLE on the next edge unconditionally.
REQ-019 Latency from the start-accepting edge to done visible: WIDTH+1 edges; issue interval: WIDTH+3 cycles.
REQ-020 start while in RUN or DONE SHALL be ignored, with no queuing.
REQ-021 Operand inputs changing during RUN SHALL NOT affect the result.
REQ-022 Hi/Lo SHALL change only at the final RUN step and at reset; otherwise they hold the last result.
REQ-023 abort=1 in RUN SHALL return the FSM to IDLE on that edge, with no done and Hi/Lo unchanged; abort has priority over the step.
REQ-024 abort in IDLE or DONE SHALL have no effect; abort and start together in IDLE SHALL start the operation.
REQ-025 Result for the signed mode SHALL be the exact two's-complement product; for unsigned mode, the exact unsigned product (no overflow is possible in 2*WIDTH bits).

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, busy=0, done=0, Hi=0, Lo=0, counter=0, and all internal registers to 0, regardless of the clock.
REQ-027 Reset asserted mid-RUN SHALL discard the operation; the first start after reset release SHALL behave as per REQ-015.

Structure
REQ-028 The FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default SHALL live in the shared package mult_pkg.
REQ-029 A combinational sub-module booth_step (inputs A, M, Q0, Q(-1); output next {A,Q,Q(-1)}) SHALL implement one add/sub-and-shift step, parametrised by WIDTH+1.

Verification
REQ-030 WIDTH=32, signed, A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0x00000000, Lo=0x00000001; done exactly 33 edges after the start edge.
REQ-031 WIDTH=32, unsigned, A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-032 WIDTH=32, signed, A=0x80000000, B=0x80000000 -> Hi=0x40000000, Lo=0x00000000; signed A=-3, B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
REQ-033 WIDTH=8, unsigned, A=200, B=200 -> Hi=0x9C, Lo=0x40; done 9 edges after the start edge.
REQ-034 Start 5x7, pulse abort at the 10th RUN cycle, with start held high throughout -> no done, Hi/Lo keep their prior values; the next start is accepted from IDLE and yields 35.
REQ-035 Assert reset mid-RUN, then release -> all outputs 0 immediately; a subsequent signed -2x3 yields Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
